// File: rtl/ppdu_sequencer_if.sv
// Handshake bundle for ppdu_sequencer: descriptor, scrambled DATA input and encoder output streams.
// The master modport is the surrounding chain (descriptor source, scrambler, encoder); slave is the sequencer.
interface ppdu_sequencer_if #(
  parameter int WIDTH    = 24,
  parameter int NW_WIDTH = 16
);
  logic [3:0]          s_desc_rate;
  logic [11:0]         s_desc_length;
  logic [NW_WIDTH-1:0] s_desc_nwords;
  logic                s_desc_valid;
  logic                s_desc_ready;

  logic [WIDTH-1:0]    s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic                s_axis_tlast;

  logic [WIDTH-1:0]    m_axis_tdata;
  logic [3:0]          m_axis_tuser;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                m_axis_tlast;

  modport master (
    output s_desc_rate, s_desc_length, s_desc_nwords, s_desc_valid,
    input  s_desc_ready,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

  modport slave (
    input  s_desc_rate, s_desc_length, s_desc_nwords, s_desc_valid,
    output s_desc_ready,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );
endinterface

// File: rtl/ppdu_sequencer.sv
// PPDU sequencer: emits the SIGNAL word at 6 Mb/s, clears the encoder, forwards DATA words with tlast,
// and clears the encoder again so each field starts from the zero state.
module ppdu_sequencer #(
  parameter int WIDTH      = 24,
  parameter int NW_WIDTH   = 16,
  parameter int CLR_CYCLES = 2
) (
  input  logic                 aclk,
  input  logic                 areset,
  ppdu_sequencer_if.slave      bus,
  output logic                 enc_clr,
  output logic                 busy,
  output logic                 err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SIG   = 3'd1;
  localparam logic [2:0] S_CLR_A = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_CLR_B = 3'd5;

  localparam int          CW       = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [3:0]  RATE_6M  = 4'b1101;

  logic [2:0]          state;
  logic [3:0]          rate_q;
  logic [NW_WIDTH-1:0] nwords_q;
  logic [NW_WIDTH-1:0] cnt;
  logic [CW-1:0]       clr_cnt;
  logic [WIDTH-1:0]    sig_q;
  logic [WIDTH-1:0]    sig_next;
  logic                err_q;
  logic                clr_done;
  logic                last_word;
  logic                data_hs;

  always_comb begin
    sig_next        = '0;
    sig_next[3:0]   = bus.s_desc_rate;
    sig_next[16:5]  = bus.s_desc_length;
    sig_next[17]    = ^{bus.s_desc_length, bus.s_desc_rate};
  end

  // nwords==0 never reaches DATA, but the guard keeps nwords-1 from wrapping.
  assign last_word = (nwords_q != '0) && (cnt == nwords_q - NW_WIDTH'(1));
  assign clr_done  = (clr_cnt == CW'(CLR_CYCLES - 1));
  assign data_hs   = (state == S_DATA) && bus.s_axis_tvalid && bus.m_axis_tready;

  always_comb begin
    bus.s_desc_ready  = (state == S_IDLE) && !areset;
    bus.s_axis_tready = 1'b0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tdata  = '0;
    bus.m_axis_tuser  = '0;
    bus.m_axis_tlast  = 1'b0;
    case (state)
      S_SIG: begin
        bus.m_axis_tvalid = 1'b1;
        bus.m_axis_tdata  = sig_q;
        bus.m_axis_tuser  = RATE_6M;
        bus.m_axis_tlast  = (nwords_q == '0);
      end
      S_DATA: begin
        bus.m_axis_tvalid = bus.s_axis_tvalid;
        bus.s_axis_tready = bus.m_axis_tready;
        bus.m_axis_tdata  = bus.s_axis_tdata;
        bus.m_axis_tuser  = rate_q;
        bus.m_axis_tlast  = last_word || bus.s_axis_tlast;
      end
      S_DRAIN: bus.s_axis_tready = 1'b1;
      default: ;
    endcase
  end

  assign enc_clr = (state == S_CLR_A) || (state == S_CLR_B);
  assign busy    = (state != S_IDLE);
  assign err     = err_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= S_IDLE;
      rate_q   <= '0;
      nwords_q <= '0;
      cnt      <= '0;
      clr_cnt  <= '0;
      sig_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.s_desc_valid) begin
          rate_q   <= bus.s_desc_rate;
          nwords_q <= bus.s_desc_nwords;
          sig_q    <= sig_next;
          cnt      <= '0;
          state    <= S_SIG;
        end
        S_SIG: if (bus.m_axis_tready) begin
          clr_cnt <= '0;
          state   <= (nwords_q != '0) ? S_CLR_A : S_CLR_B;
        end
        S_CLR_A: begin
          if (clr_done) begin
            clr_cnt <= '0;
            state   <= S_DATA;
          end else begin
            clr_cnt <= clr_cnt + CW'(1);
          end
        end
        S_DATA: if (data_hs) begin
          cnt <= cnt + NW_WIDTH'(1);
          // Early end flags err but still closes cleanly; late end drains the rest of the source frame.
          if (bus.s_axis_tlast) begin
            err_q <= !last_word;
            state <= S_CLR_B;
          end else if (last_word) begin
            err_q <= 1'b1;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: if (bus.s_axis_tvalid && bus.s_axis_tlast) state <= S_CLR_B;
        S_CLR_B: begin
          if (clr_done) begin
            clr_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            clr_cnt <= clr_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
